ext_serial_rx: RTL and testbench
================================

Name: ext_serial_rx

Overview:
- Receive end of the inter-board external serial link.
- Deserializes frames arriving on the GPIO data line (ext_data_in) using the shared oversampling tick.
- Holds each received byte in a one-entry buffer for the local bus side.
- Returns the ack_out handshake that the remote transmitter waits on before sending its next frame.

Parameters:
- DATA_WIDTH, 8, data bits per frame, sent LSB first.
- OVS, 16, tick pulses per bit period; must be even and >= 4.
- ACK_TICKS, 16, number of tick pulses for which ack_out is held high after an accepted frame.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- tick  input  1  oversample enable, one clk wide, OVS pulses per bit.
- ext_data_in  input  1  serial line from the remote board; idle high; asynchronous to clk.
- ack_out  output  1  frame-accepted handshake to the remote transmitter.
- rx_data  output  DATA_WIDTH  last accepted byte.
- rx_valid  output  1  rx_data holds an unread byte.
- rx_read  input  1  consumer pop, one clk wide.
- end_rx  output  1  one-clk pulse when a frame is loaded into rx_data.
- frame_err  output  1  sticky flag: bad stop bit (or bad parity, see Optional Feature).
- overrun  output  1  sticky flag: a good frame was dropped because the buffer was full.
- err_clr  input  1  clears frame_err and overrun.
- state_rx  output  3  current FSM state, for the LED debug display.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - FSM goes to IDLE.
  - ack_out, rx_valid, end_rx, frame_err and overrun go to 0; rx_data goes to 0.
  - Both synchronizer flops go to 1; all counters go to 0.
  - Reset mid-frame abandons the frame silently.
- Input sync: ext_data_in passes through 2 flops; all sampling uses the synced value (rxs).
- Counters and states advance only on cycles where tick=1. Without tick the block is frozen, except that the rx_read and err_clr paths are always live.
- State encodings: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, ACK=5, ERR=6.
- IDLE: on a tick with rxs=0, go to START with tick_cnt=0.
- START: on the tick where tick_cnt reaches OVS/2-1, sample rxs.
  - rxs=1: treated as a glitch; return to IDLE with no flag set.
  - rxs=0: reset tick_cnt and bit_cnt, go to DATA.
- DATA: every OVS ticks (mid-bit), shift rxs into shift_reg MSB-side so that the first bit lands at LSB.
  - After DATA_WIDTH samples, go to STOP (or to PARITY when the feature is enabled).
- STOP: sample rxs at mid-bit.
  - rxs=0: set frame_err, do not load, go to ERR.
  - rxs=1 and (rx_valid=0 or rx_read=1 in the same cycle): load rx_data, set rx_valid, pulse end_rx, go to ACK.
  - rxs=1 and buffer full without pop: set overrun, discard the byte, send no ack, go to IDLE. The remote side retransmits on ack timeout.
- ACK: ack_out=1 for exactly ACK_TICKS tick pulses, then 0, go to IDLE. Line activity during ACK is ignored.
- ERR: wait for a tick with rxs=1, then go to IDLE. This prevents a held-low line from being seen as repeated frames.
- Latency: rx_valid and end_rx assert on the clk edge that follows the tick sampling the stop-bit centre.
- rx_read while rx_valid=1 clears rx_valid on the next edge; rx_read while empty is ignored.
- Simultaneous load and pop: the load wins, and rx_valid stays 1 with the new data.
- err_clr together with a new flag-set event: the set wins.

Optional Feature:
- Macro: EXT_RX_PARITY_EN.
- Defined:
  - The PARITY state is inserted after DATA and samples one even-parity bit at mid-bit.
  - Parity is correct when the XOR of the data bits and the parity bit equals 0.
  - Mismatch sets frame_err and goes to ERR (no load, no ack).
  - Frame length becomes DATA_WIDTH+3 bits.
- Not defined: the PARITY state is unreachable and logic is removed; frames are DATA_WIDTH+2 bits.

Test Plan:
- Frame 0xA5 at OVS=16 (start 0; bits 1,0,1,0,0,1,0,1; stop 1) -> rx_data=0xA5, rx_valid=1, a single end_rx pulse, ack_out high for exactly 16 ticks, no flags.
- Line low for 4 ticks, then high -> state returns to IDLE via START; rx_valid=0, frame_err=0, ack_out=0.
- Frame 0x3C sent with stop bit 0 -> frame_err=1, no ack, state_rx=6 until line high. A following frame 0x3C is then received normally, and err_clr clears frame_err.
- Frames 0x11 then 0x22 with no rx_read -> rx_data stays 0x11, overrun=1, no ack for the second frame. rx_read then clears rx_valid on the next clk.
- Assert reset mid-DATA of 0x5A, release, resend 0x5A -> all outputs 0 during reset; the resent frame is received correctly and acked.
- EXT_RX_PARITY_EN defined: 0x07 with parity bit 1 -> accepted and acked; 0x07 with parity bit 0 -> frame_err=1, no load, no ack.

Source files
------------

// File: rtl/ext_serial_rx.sv
// rtl/ext_serial_rx.sv - receive end of the inter-board external serial link
//
// Deserializes LSB-first frames from ext_data_in using the shared oversample
// tick, buffers one byte for the local bus and answers the remote
// transmitter with an ack_out pulse of ACK_TICKS ticks per accepted frame.
// Optional even-parity bit after the data bits: define EXT_RX_PARITY_EN.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   tick         oversample enable, OVS pulses per bit
//   ext_data_in  serial line, idle high, asynchronous to clk
//   ack_out      frame-accepted handshake to the remote transmitter
//   rx_data      last accepted byte
//   rx_valid     rx_data holds an unread byte
//   rx_read      consumer pop, one clk wide
//   end_rx       one-clk pulse when rx_data is loaded
//   frame_err    sticky: bad stop bit or bad parity
//   overrun      sticky: good frame dropped, buffer full
//   err_clr      clears frame_err and overrun
//   state_rx     current FSM state for the debug display

module ext_serial_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int OVS        = 16,
  parameter int ACK_TICKS  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  ext_data_in,
  output logic                  ack_out,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_read,
  output logic                  end_rx,
  output logic                  frame_err,
  output logic                  overrun,
  input  logic                  err_clr,
  output logic [2:0]            state_rx
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_ACK    = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  localparam int CNT_MAX = (OVS > ACK_TICKS) ? OVS : ACK_TICKS;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int BW      = $clog2(DATA_WIDTH + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(OVS - 1);
  localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TICKS - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);

  logic                  sync1_q, rxs_q;
  state_t                state_q, state_d;
  logic [CW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  end_rx_q, end_rx_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic                  load, set_ferr, set_ovr;
  logic                  mid_bit;

  // Once the start bit is centred, a full bit period lands on every mid-bit.
  assign mid_bit = (tick_cnt_q == BIT_LAST);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    load       = 1'b0;
    set_ferr   = 1'b0;
    set_ovr    = 1'b0;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!rxs_q) begin
            state_d    = ST_START;
            tick_cnt_d = '0;
          end
        end
        ST_START: begin
          if (tick_cnt_q == HALF_LAST) begin
            if (rxs_q) begin
              state_d = ST_IDLE;
            end else begin
              state_d    = ST_DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (mid_bit) begin
            tick_cnt_d = '0;
            shift_d    = {rxs_q, shift_q[DATA_WIDTH-1:1]};
            bit_cnt_d  = bit_cnt_q + 1'b1;
            if (bit_cnt_q == DATA_LAST) begin
`ifdef EXT_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
`ifdef EXT_RX_PARITY_EN
        ST_PARITY: begin
          if (mid_bit) begin
            tick_cnt_d = '0;
            if ((^shift_q) ^ rxs_q) begin
              set_ferr = 1'b1;
              state_d  = ST_ERR;
            end else begin
              state_d = ST_STOP;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (mid_bit) begin
            tick_cnt_d = '0;
            if (!rxs_q) begin
              set_ferr = 1'b1;
              state_d  = ST_ERR;
            end else if (!rx_valid_q || rx_read) begin
              load    = 1'b1;
              state_d = ST_ACK;
            end else begin
              // No ack: the remote side retransmits on its ack timeout.
              set_ovr = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        ST_ACK: begin
          if (tick_cnt_q == ACK_LAST) begin
            state_d    = ST_IDLE;
            tick_cnt_d = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        ST_ERR: begin
          // Wait for the line to go idle so a stuck-low line is one error.
          if (rxs_q) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Buffer and flag paths stay live between ticks; a set/load beats a clear.
  always_comb begin
    rx_data_d   = load ? shift_q : rx_data_q;
    rx_valid_d  = load ? 1'b1 : (rx_read ? 1'b0 : rx_valid_q);
    end_rx_d    = load;
    frame_err_d = set_ferr ? 1'b1 : (err_clr ? 1'b0 : frame_err_q);
    overrun_d   = set_ovr ? 1'b1 : (err_clr ? 1'b0 : overrun_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= 1'b1;
      rxs_q       <= 1'b1;
      state_q     <= ST_IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      end_rx_q    <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= ext_data_in;
      rxs_q       <= sync1_q;
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      end_rx_q    <= end_rx_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign ack_out   = (state_q == ST_ACK);
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign end_rx    = end_rx_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign state_rx  = state_q;

endmodule

// File: tb/tb_ext_serial_rx.sv
// tb/tb_ext_serial_rx.sv - scoreboard bench for ext_serial_rx
module tb_ext_serial_rx;

  localparam int DW        = 8;
  localparam int OVS       = 16;
  localparam int ACK_TICKS = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          tick = 1'b0;
  logic          ext_data_in = 1'b1;
  logic          ack_out;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_read = 1'b0;
  logic          end_rx;
  logic          frame_err;
  logic          overrun;
  logic          err_clr = 1'b0;
  logic [2:0]    state_rx;

  int n_total = 0;
  int n_pass  = 0;
  int ack_eps = 0;
  int ack_len = 0;
  int end_cnt = 0;
  logic [DW-1:0] exp_q[$];

  ext_serial_rx #(.DATA_WIDTH(DW), .OVS(OVS), .ACK_TICKS(ACK_TICKS)) dut (
    .clk(clk), .reset(reset), .tick(tick), .ext_data_in(ext_data_in),
    .ack_out(ack_out), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_read(rx_read), .end_rx(end_rx), .frame_err(frame_err),
    .overrun(overrun), .err_clr(err_clr), .state_rx(state_rx)
  );

  always #5 clk = ~clk;

  // One-clk tick every 4 clocks, changed just after the rising edge.
  initial begin
    forever begin
      repeat (3) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitor: every end_rx pops one expected byte.
  initial begin
    forever begin
      @(negedge clk);
      if (end_rx) begin
        end_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_end_rx", {24'h0, rx_data}, 32'hFFFF_FFFF);
        end else begin
          check("rx_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
          check("rx_valid_on_end", {31'h0, rx_valid}, 32'd1);
        end
      end
    end
  end

  // Ack monitor: counts tick pulses inside each ack episode.
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_out && tick) ack_len++;
      if (prev && !ack_out) begin
        check("ack_len", ack_len, ACK_TICKS);
        ack_eps++;
        ack_len = 0;
      end
      prev = ack_out;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic wait_tick();
    do @(negedge clk); while (!tick);
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ext_data_in = b;
    repeat (OVS) wait_tick();
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic stop, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(d[i]);
`ifdef EXT_RX_PARITY_EN
    send_bit(par);
`endif
    send_bit(stop);
  endtask

  task automatic wait_ack(input string name);
    int t;
    t = 0;
    while (!ack_out && t < 3000) begin @(negedge clk); t++; end
    while (ack_out && t < 3000) begin @(negedge clk); t++; end
    check(name, {31'h0, (t < 3000)}, 32'd1);
    @(negedge clk);
  endtask

  task automatic pulse_read();
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    int eps0;
    repeat (3) @(negedge clk);
    check("reset_state", {29'h0, state_rx}, 32'd0);
    check("reset_outs", {25'h0, ack_out, rx_valid, end_rx, frame_err, overrun, rx_data[1:0]}, 32'd0);
    reset = 1'b1;
    repeat (8) wait_tick();

    // Frame 0xA5
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    wait_ack("a5_ack_seen");
    check("a5_valid", {31'h0, rx_valid}, 32'd1);
    check("a5_end_cnt", end_cnt, 32'd1);
    check("a5_flags", {30'h0, frame_err, overrun}, 32'd0);
    pulse_read();
    check("read_clears_valid", {31'h0, rx_valid}, 32'd0);

    // Start-bit glitch
    ext_data_in = 1'b0;
    repeat (4) wait_tick();
    check("glitch_in_start", {29'h0, state_rx}, 32'd1);
    ext_data_in = 1'b1;
    repeat (12) wait_tick();
    check("glitch_idle", {29'h0, state_rx}, 32'd0);
    check("glitch_outs", {29'h0, rx_valid, frame_err, ack_out}, 32'd0);

    // Bad stop bit, then a good retry
    eps0 = ack_eps;
    send_frame(8'h3C, 1'b0, 1'b0);
    check("badstop_ferr", {31'h0, frame_err}, 32'd1);
    check("badstop_err_state", {29'h0, state_rx}, 32'd6);
    check("badstop_noload", {30'h0, rx_valid, ack_out}, 32'd0);
    ext_data_in = 1'b1;
    repeat (3) wait_tick();
    check("err_to_idle", {29'h0, state_rx}, 32'd0);
    check("badstop_no_ack", ack_eps, eps0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0);
    wait_ack("3c_ack_seen");
    check("ferr_sticky", {31'h0, frame_err}, 32'd1);
    pulse_clr();
    check("err_clr_ferr", {31'h0, frame_err}, 32'd0);
    pulse_read();

    // Overrun: 0x11 kept, 0x22 dropped with no ack
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, ^8'h11);
    wait_ack("11_ack_seen");
    eps0 = ack_eps;
    send_frame(8'h22, 1'b1, ^8'h22);
    repeat (20) wait_tick();
    check("ovr_data_kept", {24'h0, rx_data}, 32'h11);
    check("ovr_flag", {31'h0, overrun}, 32'd1);
    check("ovr_no_ack", ack_eps, eps0);
    check("ovr_valid", {31'h0, rx_valid}, 32'd1);
    pulse_read();
    check("ovr_read_clears", {31'h0, rx_valid}, 32'd0);
    pulse_clr();
    check("err_clr_ovr", {31'h0, overrun}, 32'd0);

    // Reset mid-DATA of 0x5A, then resend
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    reset = 1'b0;
    #1;
    check("rst_state", {29'h0, state_rx}, 32'd0);
    check("rst_data", {24'h0, rx_data}, 32'd0);
    check("rst_outs", {27'h0, ack_out, rx_valid, end_rx, frame_err, overrun}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    ext_data_in = 1'b1;
    repeat (20) wait_tick();
    check("post_rst_idle", {29'h0, state_rx}, 32'd0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, ^8'h5A);
    wait_ack("5a_ack_seen");
    check("5a_valid", {31'h0, rx_valid}, 32'd1);
    pulse_read();

`ifdef EXT_RX_PARITY_EN
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    wait_ack("par_ok_ack");
    pulse_read();
    eps0 = ack_eps;
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (20) wait_tick();
    check("par_bad_ferr", {31'h0, frame_err}, 32'd1);
    check("par_bad_noload", {31'h0, rx_valid}, 32'd0);
    check("par_bad_no_ack", ack_eps, eps0);
    check("ack_total", ack_eps, 32'd5);
`else
    check("ack_total", ack_eps, 32'd4);
`endif
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
